approx_mult_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational 8x8 approximate multiplier.
- Multiplies two unsigned WIDTH-bit operands in either exact mode or segment-truncated approximate mode, selectable per transaction.
- Uses a valid/ready handshake on input and output, with full backpressure.
- Tracks on-chip error statistics (sample count, accumulated error, maximum error), so approximate-mode quality is measured in hardware instead of by testbench printout.

---
 rtl/approx_mult_pkg.sv | 37 +++
 rtl/seg_trunc.sv | 21 ++
 rtl/approx_mult_pipe.sv | 182 ++++++++++++++++++
 tb/tb_approx_mult_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: definitions shared by the approximate multiplier pipeline
// and its testbench.
//   MODE_EXACT / MODE_APPROX : per-beat mode encoding (in_mode / out_mode).
//   lead_one_idx             : index of the highest set bit, -1 for zero.
//   seg_trunc_val            : keeps the top `seg` significant bits of x and
//                              clears everything below them.
// Both functions work on a MAXW-bit container, so operands up to MAXW bits
// wide are handled; callers zero-extend into it and truncate the result.
package approx_mult_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int MAXW = 64;

  function automatic int lead_one_idx(input logic [MAXW-1:0] x);
    int idx;
    idx = -1;
    for (int i = 0; i < MAXW; i++) begin
      if (x[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic [MAXW-1:0] seg_trunc_val(input logic [MAXW-1:0] x,
                                                    input int seg);
    int              p;
    logic [MAXW-1:0] mask;
    p = lead_one_idx(x);
    // p == -1 (x == 0) also lands here, so zero passes through unchanged.
    if (p < seg) return x;
    // Clear bits [p-seg:0], leaving exactly `seg` bits from the leading one.
    mask = (MAXW'(1) << (p - seg + 1)) - MAXW'(1);
    return x & ~mask;
  endfunction

endpackage

// File: rtl/seg_trunc.sv
// seg_trunc: combinational single-operand truncator.
//   x  : operand, unsigned WIDTH bits.
//   en : 1 = truncate to SEG significant bits, 0 = pass x through.
//   y  : truncated (or untouched) operand.
module seg_trunc
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic             en,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = x;
    if (en) y = WIDTH'(seg_trunc_val(MAXW'(x), SEG));
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage pipelined unsigned multiplier with per-beat
// exact / segment-truncated approximate mode and on-chip error statistics.
//   clk, rst          : clock, synchronous active-high reset.
//   in_valid/in_ready : input handshake; in_a, in_b operands, in_mode mode.
//   out_valid/out_ready : output handshake; out_p product, out_err =
//                       exact - out_p, out_mode the beat's mode.
//   clear_stats       : zeroes the statistics (wins over a same-cycle retire).
//   stat_count / stat_err_sum / stat_err_max : approximate-mode statistics.
// The whole pipeline advances together (adv) so bubbles are preserved and a
// stalled output holds every stage.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 4,
  parameter int ACCW  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [2*WIDTH-1:0]   out_err,
  output logic                 out_mode,
  input  logic                 clear_stats,
  output logic [ACCW-1:0]      stat_count,
  output logic [ACCW-1:0]      stat_err_sum,
  output logic [2*WIDTH-1:0]   stat_err_max
);

  localparam int PW   = 2 * WIDTH;
  // One spare bit above the wider of the two addends catches overflow.
  localparam int SUMW = ((ACCW > PW) ? ACCW : PW) + 1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic [WIDTH-1:0] s2_at_q, s2_at_d, s2_bt_q, s2_bt_d;
  logic             s2_mode_q, s2_mode_d;

  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_p_q, out_p_d, out_err_q, out_err_d;
  logic             out_mode_q, out_mode_d;

  logic [ACCW-1:0]  stat_count_q, stat_count_d;
  logic [ACCW-1:0]  stat_sum_q, stat_sum_d;
  logic [PW-1:0]    stat_max_q, stat_max_d;

  logic             adv;
  logic             retire;
  logic [WIDTH-1:0] a_trunc, b_trunc;
  logic [PW-1:0]    prod_exact, prod_apx;
  logic [SUMW-1:0]  sum_ext;

  seg_trunc #(.WIDTH(WIDTH), .SEG(SEG)) u_trunc_a (
    .x  (s1_a_q),
    .en (s1_mode_q == MODE_APPROX),
    .y  (a_trunc)
  );

  seg_trunc #(.WIDTH(WIDTH), .SEG(SEG)) u_trunc_b (
    .x  (s1_b_q),
    .en (s1_mode_q == MODE_APPROX),
    .y  (b_trunc)
  );

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !rst;
  assign retire   = out_valid_q && out_ready;

  // Datapath: every stage loads together when the pipeline advances.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_a_d      = s2_a_q;
    s2_b_d      = s2_b_q;
    s2_at_d     = s2_at_q;
    s2_bt_d     = s2_bt_q;
    s2_mode_d   = s2_mode_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_err_d   = out_err_q;
    out_mode_d  = out_mode_q;
    prod_exact  = PW'(s2_a_q) * PW'(s2_b_q);
    prod_apx    = PW'(s2_at_q) * PW'(s2_bt_q);
    if (adv) begin
      s1_valid_d  = in_valid;
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_mode_d   = in_mode;
      s2_valid_d  = s1_valid_q;
      s2_a_d      = s1_a_q;
      s2_b_d      = s1_b_q;
      s2_at_d     = a_trunc;
      s2_bt_d     = b_trunc;
      s2_mode_d   = s1_mode_q;
      out_valid_d = s2_valid_q;
      out_p_d     = prod_apx;
      // Truncation only clears bits, so prod_apx <= prod_exact: no wrap.
      out_err_d   = prod_exact - prod_apx;
      out_mode_d  = s2_mode_q;
    end
  end

  // Statistics: only retired approximate beats count; clear has priority.
  always_comb begin
    stat_count_d = stat_count_q;
    stat_sum_d   = stat_sum_q;
    stat_max_d   = stat_max_q;
    sum_ext      = SUMW'(stat_sum_q) + SUMW'(out_err_q);
    if (clear_stats) begin
      stat_count_d = '0;
      stat_sum_d   = '0;
      stat_max_d   = '0;
    end else if (retire && (out_mode_q == MODE_APPROX)) begin
      if (stat_count_q != '1) stat_count_d = stat_count_q + ACCW'(1);
      if (sum_ext > SUMW'({ACCW{1'b1}})) stat_sum_d = '1;
      else                               stat_sum_d = ACCW'(sum_ext);
      if (out_err_q > stat_max_q) stat_max_d = out_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_mode_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_a_q       <= '0;
      s2_b_q       <= '0;
      s2_at_q      <= '0;
      s2_bt_q      <= '0;
      s2_mode_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_p_q      <= '0;
      out_err_q    <= '0;
      out_mode_q   <= 1'b0;
      stat_count_q <= '0;
      stat_sum_q   <= '0;
      stat_max_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_mode_q    <= s1_mode_d;
      s2_valid_q   <= s2_valid_d;
      s2_a_q       <= s2_a_d;
      s2_b_q       <= s2_b_d;
      s2_at_q      <= s2_at_d;
      s2_bt_q      <= s2_bt_d;
      s2_mode_q    <= s2_mode_d;
      out_valid_q  <= out_valid_d;
      out_p_q      <= out_p_d;
      out_err_q    <= out_err_d;
      out_mode_q   <= out_mode_d;
      stat_count_q <= stat_count_d;
      stat_sum_q   <= stat_sum_d;
      stat_max_q   <= stat_max_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_p        = out_p_q;
  assign out_err      = out_err_q;
  assign out_mode     = out_mode_q;
  assign stat_count   = stat_count_q;
  assign stat_err_sum = stat_sum_q;
  assign stat_err_max = stat_max_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed testbench for approx_mult_pipe (WIDTH=8, SEG=4, ACCW=32).
module tb_approx_mult_pipe;

  localparam int WIDTH = 8;
  localparam int SEG   = 4;
  localparam int ACCW  = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a, in_b;
  logic               in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p, out_err;
  logic               out_mode;
  logic               clear_stats;
  logic [ACCW-1:0]    stat_count, stat_err_sum;
  logic [2*WIDTH-1:0] stat_err_max;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  approx_mult_pipe #(.WIDTH(WIDTH), .SEG(SEG), .ACCW(ACCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_p        (out_p),
    .out_err      (out_err),
    .out_mode     (out_mode),
    .clear_stats  (clear_stats),
    .stat_count   (stat_count),
    .stat_err_sum (stat_err_sum),
    .stat_err_max (stat_err_max)
  );

  // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    out_ready = 1'b1; clear_stats = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (out_p !== 16'd0 || out_err !== 16'd0 || out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_data: got p=%0d err=%0d mode=%0b want 0/0/0", out_p, out_err, out_mode); end
    checks++; if (stat_count !== 32'd0 || stat_err_sum !== 32'd0 || stat_err_max !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_count, stat_err_sum, stat_err_max); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_a = 8'd100; in_b = 8'd200; in_mode = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: got out_valid=%0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got out_valid=%0b want 1", out_valid); end
    checks++; if (out_p !== 16'd18432 || out_err !== 16'd1568 || out_mode !== 1'b1) begin errors++; $display("FAIL single_result: got p=%0d err=%0d mode=%0b want 18432/1568/1", out_p, out_err, out_mode); end
    $display("beat single a=100 b=200 approx p=%0d err=%0d", out_p, out_err);
    tick();
    checks++; if (stat_count !== 32'd1 || stat_err_sum !== 32'd1568 || stat_err_max !== 16'd1568) begin errors++; $display("FAIL single_stats: got %0d/%0d/%0d want 1/1568/1568", stat_count, stat_err_sum, stat_err_max); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] ep [4];
    logic [15:0] ee [4];
    va = '{8'd255, 8'd12, 8'd128, 8'd255};
    vb = '{8'd255, 8'd15, 8'd128, 8'd1};
    ep = '{16'd57600, 16'd180, 16'd16384, 16'd240};
    ee = '{16'd7425, 16'd0, 16'd0, 16'd15};
    // Start from clean statistics so the totals below cover just these beats.
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checks++; if (stat_count !== 32'd0 || stat_err_max !== 16'd0) begin errors++; $display("FAIL clear_idle: got count=%0d max=%0d want 0/0", stat_count, stat_err_max); end
    for (int t = 1; t <= 7; t++) begin
      if (t <= 4) begin
        in_valid = 1'b1; in_a = va[t-1]; in_b = vb[t-1]; in_mode = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (t >= 3 && t <= 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_p !== ep[t-3] || out_err !== ee[t-3]) begin
          errors++;
          $display("FAIL b2b_beat%0d: got v=%0b p=%0d err=%0d want 1/%0d/%0d", t-3, out_valid, out_p, out_err, ep[t-3], ee[t-3]);
        end
        $display("beat b2b%0d approx p=%0d err=%0d", t-3, out_p, out_err);
      end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got out_valid=%0b want 0", out_valid); end
    checks++; if (stat_count !== 32'd4 || stat_err_sum !== 32'd7440 || stat_err_max !== 16'd7425) begin errors++; $display("FAIL b2b_stats: got %0d/%0d/%0d want 4/7440/7425", stat_count, stat_err_sum, stat_err_max); end
  endtask

  task automatic test_exact();
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_p !== 16'd65025 || out_err !== 16'd0 || out_mode !== 1'b0) begin errors++; $display("FAIL exact_result: got v=%0b p=%0d err=%0d mode=%0b want 1/65025/0/0", out_valid, out_p, out_err, out_mode); end
    $display("beat exact a=255 b=255 p=%0d err=%0d", out_p, out_err);
    tick();
    checks++; if (stat_count !== 32'd4 || stat_err_sum !== 32'd7440 || stat_err_max !== 16'd7425) begin errors++; $display("FAIL exact_stats: got %0d/%0d/%0d want 4/7440/7425", stat_count, stat_err_sum, stat_err_max); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  va [6];
    logic [7:0]  vb [6];
    logic        vm [6];
    logic [15:0] ep [6];
    logic [15:0] ee [6];
    int          tx, rx, stall_seen;
    logic        have_hold, accepted;
    logic [15:0] hold_p, hold_e;
    va = '{8'd100, 8'd255, 8'd12, 8'd255, 8'd50, 8'd17};
    vb = '{8'd200, 8'd255, 8'd15, 8'd1,   8'd3,  8'd33};
    vm = '{1'b1,   1'b0,   1'b1,  1'b1,   1'b0,  1'b1};
    ep = '{16'd18432, 16'd65025, 16'd180, 16'd240, 16'd150, 16'd512};
    ee = '{16'd1568,  16'd0,     16'd0,   16'd15,  16'd0,   16'd49};
    tx = 0; rx = 0; stall_seen = 0; have_hold = 1'b0; hold_p = '0; hold_e = '0;
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      if (tx < 6) begin
        in_valid = 1'b1; in_a = va[tx]; in_b = vb[tx]; in_mode = vm[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        stall_seen++;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %0b want 0", cyc, in_ready); end
        if (have_hold) begin
          checks++;
          if (out_p !== hold_p || out_err !== hold_e) begin errors++; $display("FAIL bp_stable cyc%0d: got p=%0d err=%0d want %0d/%0d", cyc, out_p, out_err, hold_p, hold_e); end
        end
        hold_p = out_p; hold_e = out_err; have_hold = 1'b1;
      end else begin
        have_hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_p !== ep[rx] || out_err !== ee[rx] || out_mode !== vm[rx]) begin
          errors++;
          $display("FAIL bp_beat%0d: got p=%0d err=%0d mode=%0b want %0d/%0d/%0b", rx, out_p, out_err, out_mode, ep[rx], ee[rx], vm[rx]);
        end
        $display("beat bp%0d p=%0d err=%0d mode=%0b", rx, out_p, out_err, out_mode);
        rx++;
      end
      accepted = in_valid && in_ready;
      tick();
      if (accepted) tx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rx != 6) begin errors++; $display("FAIL bp_count: got %0d beats want 6", rx); end
    checks++; if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", stall_seen); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_clear_same_cycle();
    in_valid = 1'b1; in_a = 8'd100; in_b = 8'd200; in_mode = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      tick();
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL clear_timeout: got out_valid=%0b want 1", out_valid);
    end else begin
      checks++; if (stat_count === 32'd0) begin errors++; $display("FAIL clear_precond: got count=%0d want nonzero", stat_count); end
      clear_stats = 1'b1;
      checks++; if (out_p !== 16'd18432 || out_err !== 16'd1568) begin errors++; $display("FAIL clear_beat: got p=%0d err=%0d want 18432/1568", out_p, out_err); end
      $display("beat clear a=100 b=200 approx p=%0d err=%0d", out_p, out_err);
      tick();
      clear_stats = 1'b0;
      checks++; if (stat_count !== 32'd0 || stat_err_sum !== 32'd0 || stat_err_max !== 16'd0) begin errors++; $display("FAIL clear_stats: got %0d/%0d/%0d want 0/0/0", stat_count, stat_err_sum, stat_err_max); end
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 8'd100 + 8'(i); in_b = 8'd200; in_mode = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (stat_count !== 32'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL rstflight_precond: got count=%0d v=%0b want 1/1", stat_count, out_valid); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstflight_flush: got v=%0b rdy=%0b want 0/0", out_valid, in_ready); end
    checks++; if (stat_count !== 32'd0 || stat_err_sum !== 32'd0 || stat_err_max !== 16'd0) begin errors++; $display("FAIL rstflight_stats: got %0d/%0d/%0d want 0/0/0", stat_count, stat_err_sum, stat_err_max); end
    rst = 1'b0;
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd1; in_mode = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstflight_stale: got out_valid=%0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_p !== 16'd240 || out_err !== 16'd15) begin errors++; $display("FAIL rstflight_first: got v=%0b p=%0d err=%0d want 1/240/15", out_valid, out_p, out_err); end
    $display("beat post_reset a=255 b=1 approx p=%0d err=%0d", out_p, out_err);
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_exact();
    test_backpressure();
    test_clear_same_cycle();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
